// File: rtl/bram_port_arbiter_if.sv
// Requester and BRAM-port signals of the two-requester BRAM arbiter.
// master: requesters plus BRAM (environment side); slave: the arbiter.
interface bram_port_arbiter_if #(
  parameter int P_DATA_WIDTH    = 16,
  parameter int P_ADDRESS_WIDTH = 10
);
  logic                       req_0;
  logic                       req_1;
  logic                       we_0;
  logic                       we_1;
  logic [P_ADDRESS_WIDTH-1:0] address_0;
  logic [P_ADDRESS_WIDTH-1:0] address_1;
  logic [P_DATA_WIDTH-1:0]    wdata_0;
  logic [P_DATA_WIDTH-1:0]    wdata_1;
  logic                       gnt_0;
  logic                       gnt_1;
  logic                       valid_0;
  logic                       valid_1;
  logic [P_DATA_WIDTH-1:0]    rdata_0;
  logic [P_DATA_WIDTH-1:0]    rdata_1;
  logic [P_ADDRESS_WIDTH-1:0] bram_address;
  logic [P_DATA_WIDTH-1:0]    bram_wdata;
  logic                       bram_write_enable;
  logic [P_DATA_WIDTH-1:0]    bram_rdata;

  modport master (
    output req_0, req_1, we_0, we_1, address_0, address_1, wdata_0, wdata_1,
    input  gnt_0, gnt_1, valid_0, valid_1, rdata_0, rdata_1,
    input  bram_address, bram_wdata, bram_write_enable,
    output bram_rdata
  );

  modport slave (
    input  req_0, req_1, we_0, we_1, address_0, address_1, wdata_0, wdata_1,
    output gnt_0, gnt_1, valid_0, valid_1, rdata_0, rdata_1,
    output bram_address, bram_wdata, bram_write_enable,
    input  bram_rdata
  );
endinterface

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one BRAM port between two single-word requesters.
// Read-return tag stages:
//   tag      | meaning
//   TAG_NONE | no read in this stage (idle or write)
//   TAG_RD0  | read issued for requester 0
//   TAG_RD1  | read issued for requester 1
module bram_port_arbiter #(
  parameter int P_DATA_WIDTH    = 16,
  parameter int P_ADDRESS_WIDTH = 10
) (
  input logic                I_CLK,
  input logic                I_NRESET,
  bram_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_RD0  = 2'd1,
    TAG_RD1  = 2'd2
  } tag_t;

  tag_t                       tag_s1;
  tag_t                       tag_s1_nxt;
  tag_t                       tag_s2;
  logic                       last_winner;
  logic                       last_winner_nxt;
  logic                       gnt_0;
  logic                       gnt_1;
  logic                       gnt_0_nxt;
  logic                       gnt_1_nxt;
  logic                       we;
  logic                       we_nxt;
  logic [P_ADDRESS_WIDTH-1:0] address;
  logic [P_ADDRESS_WIDTH-1:0] address_nxt;
  logic [P_DATA_WIDTH-1:0]    wdata;
  logic [P_DATA_WIDTH-1:0]    wdata_nxt;
  logic                       elig_0;
  logic                       elig_1;
  logic                       pick_1;

  // A live grant masks its own request so a held request is taken only once.
  always_comb begin
    elig_0          = bus.req_0 & ~gnt_0;
    elig_1          = bus.req_1 & ~gnt_1;
    pick_1          = elig_1 & (~elig_0 | ~last_winner);
    gnt_0_nxt       = 1'b0;
    gnt_1_nxt       = 1'b0;
    we_nxt          = 1'b0;
    address_nxt     = address;
    wdata_nxt       = wdata;
    last_winner_nxt = last_winner;
    tag_s1_nxt      = TAG_NONE;
    if (pick_1) begin
      gnt_1_nxt       = 1'b1;
      we_nxt          = bus.we_1;
      address_nxt     = bus.address_1;
      wdata_nxt       = bus.wdata_1;
      last_winner_nxt = 1'b1;
      if (!bus.we_1) tag_s1_nxt = TAG_RD1;
    end else if (elig_0) begin
      gnt_0_nxt       = 1'b1;
      we_nxt          = bus.we_0;
      address_nxt     = bus.address_0;
      wdata_nxt       = bus.wdata_0;
      last_winner_nxt = 1'b0;
      if (!bus.we_0) tag_s1_nxt = TAG_RD0;
    end
  end

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      gnt_0       <= 1'b0;
      gnt_1       <= 1'b0;
      we          <= 1'b0;
      address     <= '0;
      wdata       <= '0;
      last_winner <= 1'b1;
      tag_s1      <= TAG_NONE;
      tag_s2      <= TAG_NONE;
    end else begin
      gnt_0       <= gnt_0_nxt;
      gnt_1       <= gnt_1_nxt;
      we          <= we_nxt;
      address     <= address_nxt;
      wdata       <= wdata_nxt;
      last_winner <= last_winner_nxt;
      tag_s1      <= tag_s1_nxt;
      tag_s2      <= tag_s1;
    end
  end

  assign bus.gnt_0             = gnt_0;
  assign bus.gnt_1             = gnt_1;
  assign bus.bram_address      = address;
  assign bus.bram_wdata        = wdata;
  assign bus.bram_write_enable = we;
  assign bus.valid_0           = (tag_s2 == TAG_RD0);
  assign bus.valid_1           = (tag_s2 == TAG_RD1);
  assign bus.rdata_0           = bus.bram_rdata;
  assign bus.rdata_1           = bus.bram_rdata;

endmodule
